alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares the single 32-bit ALU between NREQ requesters (decoder, branch unit, address gen).
//   Accepts one op at a time over valid/ready, drives the ALU's en/fn/src1/src2 and returns the result
//   to the granted requester. The result is held until that requester consumes it.
//   Sits between the requesters and the ALU; the ALU's res output feeds back into this block.
// PARAMETERS
//   NREQ   2   number of requesters, legal 2..8
//   IDXW   3   grant index width, must be >= clog2(NREQ)
// PORTS
//   clk         in   1          clock, all state on posedge
//   rst         in   1          asynchronous reset, active-high
//   req_valid   in   NREQ       request i has an op pending
//   req_ready   out  NREQ       request i accepted this cycle (one-hot or zero)
//   req_fn      in   4*NREQ     ALU function code, slice i = [4*i+:4]
//   req_src1    in   32*NREQ    operand 1, slice i = [32*i+:32]
//   req_src2    in   32*NREQ    operand 2, slice i = [32*i+:32]
//   rsp_valid   out  NREQ       result ready for requester i (one-hot or zero)
//   rsp_ready   in   NREQ       requester i consumes result
//   rsp_data    out  32         result, valid while any rsp_valid bit is set
//   alu_en      out  1          ALU enable, registered
//   alu_fn      out  4          ALU function, registered
//   alu_src1    out  32         ALU operand 1, registered
//   alu_src2    out  32         ALU operand 2, registered
//   alu_res     in   32         ALU result; registered inside the ALU, 1 cycle after alu_en
//   busy        out  1          state != IDLE
//   grant_idx   out  IDXW       index of current/last granted requester
// BEHAVIOUR
//   FSM IDLE -> EXEC -> RESP -> IDLE.
//   - IDLE: if any req_valid, pick winner w; req_ready[w]=1 (combinational, IDLE only).
//     Latch fn/src of w into alu_*, grant_idx<=w, go EXEC. No valid: stay IDLE.
//   - EXEC: alu_en=1 for exactly this cycle. The ALU captures at the end of EXEC. Go RESP.
//   - RESP: rsp_valid[grant_idx]=1; rsp_data=alu_res, stable because alu_en=0.
//     Stay in RESP until rsp_ready[grant_idx]=1, then go IDLE.
//   - rsp_ready bits of non-granted requesters are ignored.
//   Latency: accept in cycle T, alu_en in T+1, rsp_valid in T+2. Minimum 3 cycles per op.
//   Requesters hold req_valid/fn/src stable until req_ready. A dropped req_valid before grant is legal.
//   Reset values: state=IDLE, alu_en=0, alu_fn=0, alu_src1=0, alu_src2=0,
//     grant_idx=0, rr_ptr=0, req_ready=0, rsp_valid=0, busy=0.
//   Reset mid-operation: abort immediately. The pending result is dropped and no rsp_valid is issued.
//   req_valid arriving in EXEC/RESP is not accepted and waits for IDLE.
//   fn is passed through unchecked; unsupported codes return whatever the ALU produces (0).
//   req_valid bits at index >= NREQ do not exist; grant_idx never exceeds NREQ-1.
// CONFIGURATION
//   ALU_ARB_RR_EN defined: round-robin. rr_ptr points one past the last winner, wrapping NREQ-1 -> 0.
//     The winner is the first valid index at or after rr_ptr.
//     rr_ptr updates only on acceptance (to w+1 mod NREQ).
//   ALU_ARB_RR_EN undefined: fixed priority, lowest index wins. rr_ptr is absent.
// TESTING
//   1 reset: rst=1 mid-RESP -> next cycle rsp_valid=0, alu_en=0, busy=0, state IDLE.
//   2 single op: req0 ADD(fn=0) 5,7 -> alu_en at T+1, rsp_valid=01 at T+2,
//     rsp_data=12, holds with rsp_ready=0 for 4 cycles.
//   3 backpressure: req1 SUB(fn=7) 10,3, rsp_ready held low 3 cycles -> rsp_data=7 stable;
//     req0 stays unaccepted until rsp_ready[1] and return to IDLE.
//   4 contention, RR_EN: req0,req1 both valid continuously -> grants alternate 0,1,0,1;
//     fixed priority -> req0 always wins while valid.
//   5 wrap: NREQ=4, RR_EN, last winner 3, valid=1001 -> winner 0, next winner 3.
//   6 stray rsp_ready: rsp_ready[0]=1 while grant_idx=1 in RESP -> no state change, rsp_valid unchanged.

Source files
------------

// File: rtl/alu_arbiter.sv
// Shares one registered-input ALU among NREQ requesters over valid/ready.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_fn,
    input  logic [32*NREQ-1:0]   req_src1,
    input  logic [32*NREQ-1:0]   req_src2,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 alu_en,
    output logic [3:0]           alu_fn,
    output logic [31:0]          alu_src1,
    output logic [31:0]          alu_src2,
    input  logic [31:0]          alu_res,
    output logic                 busy,
    output logic [IDXW-1:0]      grant_idx
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic            alu_en_q, alu_en_d;
    logic [3:0]      alu_fn_q, alu_fn_d;
    logic [31:0]     alu_src1_q, alu_src1_d;
    logic [31:0]     alu_src2_q, alu_src2_d;
    logic [IDXW-1:0] grant_idx_q, grant_idx_d;

    logic            win_vld;
    logic [IDXW-1:0] win_idx;
    logic [3:0]      sel_fn;
    logic [31:0]     sel_src1;
    logic [31:0]     sel_src2;
    logic            rsp_take;

`ifdef ALU_ARB_RR_EN
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDXW:0]   dist;
    logic [IDXW:0]   best_dist;

    // Winner is the valid requester at the smallest circular distance from rr_ptr.
    always_comb begin
        win_vld   = 1'b0;
        win_idx   = '0;
        dist      = '0;
        best_dist = '1;
        for (int i = 0; i < NREQ; i++) begin
            if (i >= int'(rr_ptr_q)) dist = (IDXW+1)'(i) - {1'b0, rr_ptr_q};
            else                     dist = (IDXW+1)'(i + NREQ) - {1'b0, rr_ptr_q};
            if (req_valid[i] && (dist < best_dist)) begin
                best_dist = dist;
                win_vld   = 1'b1;
                win_idx   = IDXW'(i);
            end
        end
    end
`else
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_vld = 1'b1;
                win_idx = IDXW'(i);
            end
        end
    end
`endif

    always_comb begin
        sel_fn    = '0;
        sel_src1  = '0;
        sel_src2  = '0;
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDXW'(i)) begin
                sel_fn   = req_fn[4*i +: 4];
                sel_src1 = req_src1[32*i +: 32];
                sel_src2 = req_src2[32*i +: 32];
            end
            req_ready[i] = (state_q == IDLE) && win_vld && (win_idx == IDXW'(i));
            rsp_valid[i] = (state_q == RESP) && (grant_idx_q == IDXW'(i));
        end
        // Masking with rsp_valid makes stray rsp_ready bits of other requesters harmless.
        rsp_take = |(rsp_ready & rsp_valid);
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        alu_en_d    = 1'b0;
        alu_fn_d    = alu_fn_q;
        alu_src1_d  = alu_src1_q;
        alu_src2_d  = alu_src2_q;
        grant_idx_d = grant_idx_q;
`ifdef ALU_ARB_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d     = EXEC;
                    alu_en_d    = 1'b1;
                    alu_fn_d    = sel_fn;
                    alu_src1_d  = sel_src1;
                    alu_src2_d  = sel_src2;
                    grant_idx_d = win_idx;
`ifdef ALU_ARB_RR_EN
                    rr_ptr_d    = (win_idx == IDXW'(NREQ-1)) ? '0 : win_idx + 1'b1;
`endif
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_take) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_en_q    <= 1'b0;
            alu_fn_q    <= '0;
            alu_src1_q  <= '0;
            alu_src2_q  <= '0;
            grant_idx_q <= '0;
`ifdef ALU_ARB_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            alu_en_q    <= alu_en_d;
            alu_fn_q    <= alu_fn_d;
            alu_src1_q  <= alu_src1_d;
            alu_src2_q  <= alu_src2_d;
            grant_idx_q <= grant_idx_d;
`ifdef ALU_ARB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign alu_en    = alu_en_q;
    assign alu_fn    = alu_fn_q;
    assign alu_src1  = alu_src1_q;
    assign alu_src2  = alu_src2_q;
    assign grant_idx = grant_idx_q;
    assign busy      = (state_q != IDLE);
    assign rsp_data  = alu_res;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a small registered ALU stub.
// Define ALU_ARB_RR_EN to check round-robin instead of fixed-priority arbitration.
module tb_alu_arbiter;
    localparam int NREQ = 4;
    localparam int IDXW = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [4*NREQ-1:0]   req_fn = '0;
    logic [32*NREQ-1:0]  req_src1 = '0;
    logic [32*NREQ-1:0]  req_src2 = '0;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready = '0;
    logic [31:0]         rsp_data;
    logic                alu_en;
    logic [3:0]          alu_fn;
    logic [31:0]         alu_src1, alu_src2;
    logic [31:0]         alu_res = '0;
    logic                busy;
    logic [IDXW-1:0]     grant_idx;

    alu_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_fn(req_fn),
        .req_src1(req_src1), .req_src2(req_src2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_en(alu_en), .alu_fn(alu_fn), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_res(alu_res), .busy(busy), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            4'd0:    return a + b;
            4'd1:    return a & b;
            4'd2:    return a | b;
            4'd3:    return a ^ b;
            4'd7:    return a - b;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) if (alu_en) alu_res <= alu_ref(alu_fn, alu_src1, alu_src2);

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          acc;
        bit          seen;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [NREQ-1:0] v_valid  = '0;
    logic [NREQ-1:0] v_rready = '0;
    logic [3:0]      v_fn [NREQ];
    logic [31:0]     v_s1 [NREQ];
    logic [31:0]     v_s2 [NREQ];
    int              acc_w = -1;

    bit          m_busy  = 0;
    int          m_grant = 0;
    int          m_acc   = -10;
    int          m_ptr   = 0;
    logic [3:0]  m_fn    = '0;
    logic [31:0] m_s1    = '0;
    logic [31:0] m_s2    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v);
`ifdef ALU_ARB_RR_EN
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (v[j]) return j;
        end
`else
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`endif
        return -1;
    endfunction

    task automatic new_op(input int i);
        v_fn[i] = 4'($urandom_range(0, 15));
        v_s1[i] = $urandom;
        v_s2[i] = $urandom;
    endtask

    task automatic model_reset();
        m_busy = 0; m_grant = 0; m_acc = -10; m_ptr = 0;
        sb.delete();
    endtask

    // One clock cycle: apply inputs, check handshake-side outputs against the model, advance the model.
    task automatic drive_cycle();
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = v_valid[i];
            req_fn[4*i +: 4]     = v_fn[i];
            req_src1[32*i +: 32] = v_s1[i];
            req_src2[32*i +: 32] = v_s2[i];
        end
        rsp_ready = v_rready;
        #1;
        check("busy", 32'(busy), 32'(m_busy));
        check("grant_idx", 32'(grant_idx), 32'(m_grant));
        check("alu_en", 32'(alu_en), 32'(m_busy && (cyc == m_acc + 1)));
        if (m_busy && (cyc == m_acc + 1)) begin
            check("alu_fn", 32'(alu_fn), 32'(m_fn));
            check("alu_src1", alu_src1, m_s1);
            check("alu_src2", alu_src2, m_s2);
        end
        acc_w   = -1;
        exp_rdy = '0;
        if (!m_busy && (v_valid != '0)) begin
            acc_w = pick(v_valid);
            exp_rdy[acc_w] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (acc_w >= 0) begin
            sb.push_back('{idx: acc_w, data: alu_ref(v_fn[acc_w], v_s1[acc_w], v_s2[acc_w]), acc: cyc, seen: 0});
            m_busy = 1; m_grant = acc_w; m_acc = cyc; m_ptr = (acc_w + 1) % NREQ;
            m_fn = v_fn[acc_w]; m_s1 = v_s1[acc_w]; m_s2 = v_s2[acc_w];
        end else if (m_busy && (cyc >= m_acc + 2) && v_rready[m_grant]) begin
            m_busy = 0;
        end
    endtask

    task automatic finish_ops();
        v_valid  = '0;
        v_rready = '1;
        for (int k = 0; k < 20 && (m_busy || sb.size() != 0); k++) drive_cycle();
        check("drain", 32'(m_busy || sb.size() != 0), 32'd0);
        v_rready = '0;
    endtask

    task automatic run_until_accept(output int w);
        w = -1;
        for (int k = 0; k < 20 && w < 0; k++) begin
            drive_cycle();
            w = acc_w;
        end
        if (w < 0) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Response monitor: compares whatever the DUT presents on rsp_* against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) continue;
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb[0];
                    check("rsp_valid", 32'(rsp_valid), 32'd1 << e.idx);
                    check("rsp_data", rsp_data, e.data);
                    if (!e.seen) begin
                        check("rsp_latency", 32'(cyc - e.acc), 32'd2);
                        sb[0].seen = 1;
                    end
                    if (rsp_ready[e.idx]) void'(sb.pop_front());
                end
            end else if (sb.size() != 0 && cyc >= sb[0].acc + 2) begin
                check("rsp_missing", 32'd0, 32'd1);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int wins [4];
        int nw;
        for (int i = 0; i < NREQ; i++) begin v_fn[i] = '0; v_s1[i] = '0; v_s2[i] = '0; end

        // Reset values.
        @(negedge clk); #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_en", 32'(alu_en), 32'd0);
        check("rst_alu_fn", 32'(alu_fn), 32'd0);
        check("rst_alu_src1", alu_src1, 32'd0);
        check("rst_alu_src2", alu_src2, 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Reset in the middle of RESP drops the result.
        v_valid = 4'b0100; v_fn[2] = 4'd3; v_s1[2] = 32'hF0F0_0000; v_s2[2] = 32'h0FF0_1234;
        drive_cycle();
        check("t1_accept", 32'(acc_w), 32'd2);
        v_valid = '0;
        drive_cycle();
        drive_cycle();
        check("t1_in_resp", 32'(rsp_valid), 32'b0100);
        rst = 1'b1;
        @(negedge clk); #1;
        check("t1_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t1_alu_en", 32'(alu_en), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        model_reset();

        // Single ADD on requester 0, result held under backpressure.
        v_valid = 4'b0001; v_fn[0] = 4'd0; v_s1[0] = 32'd5; v_s2[0] = 32'd7; v_rready = '0;
        drive_cycle();
        check("t2_accept", 32'(acc_w), 32'd0);
        v_valid = '0;
        drive_cycle();
        check("t2_alu_en", 32'(alu_en), 32'd1);
        for (int k = 0; k < 4; k++) begin
            drive_cycle();
            check("t2_rsp_valid", 32'(rsp_valid), 32'b0001);
            check("t2_rsp_data", rsp_data, 32'd12);
        end
        finish_ops();

        // SUB on requester 1 with stray rsp_ready[0]; requester 0 waits meanwhile.
        v_valid = 4'b0010; v_fn[1] = 4'd7; v_s1[1] = 32'd10; v_s2[1] = 32'd3;
        drive_cycle();
        check("t3_accept", 32'(acc_w), 32'd1);
        v_valid = 4'b0001; v_fn[0] = 4'd2; v_s1[0] = 32'h11; v_s2[0] = 32'h22;
        drive_cycle();
        v_rready = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            drive_cycle();
            check("t3_rsp_valid", 32'(rsp_valid), 32'b0010);
            check("t3_rsp_data", rsp_data, 32'd7);
            check("t3_req_ready", 32'(req_ready), 32'd0);
        end
        v_rready = 4'b0010;
        drive_cycle();
        check("t3_no_accept_in_resp", 32'(req_ready), 32'd0);
        v_rready = '0;
        drive_cycle();
        check("t3_req0_after_idle", 32'(acc_w), 32'd0);
        finish_ops();

        // Wrap: last winner 3, then requesters 0 and 3 both pending.
        v_valid = 4'b1000; new_op(3);
        run_until_accept(w);
        check("t5_first", 32'(w), 32'd3);
        finish_ops();
        v_valid = 4'b1001; new_op(0); new_op(3); v_rready = '1;
        run_until_accept(w);
        check("t5_wrap_winner", 32'(w), 32'd0);
        new_op(0);
        run_until_accept(w);
`ifdef ALU_ARB_RR_EN
        check("t5_next_winner", 32'(w), 32'd3);
`else
        check("t5_next_winner", 32'(w), 32'd0);
`endif
        finish_ops();

        // Continuous contention between requesters 0 and 1.
        v_valid = 4'b0011; new_op(0); new_op(1); v_rready = '1; nw = 0;
        for (int k = 0; k < 40 && nw < 4; k++) begin
            drive_cycle();
            if (acc_w >= 0) begin
                wins[nw] = acc_w;
                nw++;
                new_op(acc_w);
            end
        end
        check("t4_count", 32'(nw), 32'd4);
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
            check("t4_grant_seq", 32'(wins[k]), 32'(k % 2));
`else
            check("t4_grant_seq", 32'(wins[k]), 32'd0);
`endif
        end
        finish_ops();

        // Random traffic with dropped requests and random (often stray) rsp_ready.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v_valid[i] || acc_w == i) begin
                    v_valid[i] = 1'($urandom_range(0, 1));
                    new_op(i);
                end else if ($urandom_range(0, 7) == 0) begin
                    v_valid[i] = 1'b0;
                end
            end
            v_rready = NREQ'($urandom);
            drive_cycle();
        end
        finish_ops();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
